// File: rtl/pdm_cic_decimator.sv
// 3rd-order CIC decimator: 1-bit PDM stream in, 16-bit unsigned PCM out (R = 2^DECIM_LOG2).
// Optional macro PDM_CIC_INPUT_SYNC_EN inserts a 2-flop input synchronizer (+2 cycles latency).
module pdm_cic_decimator #(
  parameter int unsigned DECIM_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pdm_in,
  input  logic        sample_en,
  output logic [15:0] pcm_out,
  output logic        pcm_valid,
  output logic        warm
);

  localparam int unsigned ACC_W = 3 * DECIM_LOG2 + 1;
  localparam int unsigned SHIFT = 3 * DECIM_LOG2 - 16;

  logic pdm_eff;
  logic en_eff;

`ifdef PDM_CIC_INPUT_SYNC_EN
  // Strobe and data share the same depth so their pairing survives the synchronizer.
  logic [1:0] pdm_sync_q;
  logic [1:0] en_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdm_sync_q <= '0;
      en_sync_q  <= '0;
    end else begin
      pdm_sync_q <= {pdm_sync_q[0], pdm_in};
      en_sync_q  <= {en_sync_q[0], sample_en};
    end
  end

  assign pdm_eff = pdm_sync_q[1];
  assign en_eff  = en_sync_q[1];
`else
  assign pdm_eff = pdm_in;
  assign en_eff  = sample_en;
`endif

  logic [ACC_W-1:0]      i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic [ACC_W-1:0]      d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic                  tick_q, tick_d;
  logic [1:0]            wup_q, wup_d;
  logic [15:0]           pcm_q, pcm_d;
  logic                  valid_q, valid_d;
  logic                  warm_q, warm_d;

  logic [ACC_W-1:0]      x;
  logic [ACC_W-1:0]      c1, c2, c3;
  logic [ACC_W-1:0]      scaled;

  // Integrators run modulo 2^ACC_W; the combs cancel the wrap.
  always_comb begin
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    wup_d   = wup_q;
    pcm_d   = pcm_q;
    valid_d = 1'b0;

    x      = {{(ACC_W-1){1'b0}}, pdm_eff};
    c1     = i3_q - d1_q;
    c2     = c1 - d2_q;
    c3     = c2 - d3_q;
    scaled = c3 >> SHIFT;

    if (en_eff) begin
      i1_d   = i1_q + x;
      i2_d   = i2_q + i1_q;
      i3_d   = i3_q + i2_q;
      cnt_d  = cnt_q + DECIM_LOG2'(1);
      tick_d = &cnt_q;
    end

    if (tick_q) begin
      d1_d    = i3_q;
      d2_d    = c1;
      d3_d    = c2;
      pcm_d   = (|scaled[ACC_W-1:16]) ? 16'hFFFF : scaled[15:0];
      valid_d = (wup_q == 2'd3);
      if (wup_q != 2'd3) begin
        wup_d = wup_q + 2'd1;
      end
    end

    warm_d = (wup_d == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      wup_q   <= 2'd0;
      pcm_q   <= 16'h0000;
      valid_q <= 1'b0;
      warm_q  <= 1'b0;
    end else begin
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      wup_q   <= wup_d;
      pcm_q   <= pcm_d;
      valid_q <= valid_d;
      warm_q  <= warm_d;
    end
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = valid_q;
  assign warm      = warm_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator: directed and random PDM traffic against an FIR-form CIC model.
// Honours PDM_CIC_INPUT_SYNC_EN by delaying the model inputs by 2 cycles.
module tb_pdm_cic_decimator;

  localparam int DL    = 6;
  localparam int R     = 1 << DL;
  localparam int SHIFT = 3 * DL - 16;
`ifdef PDM_CIC_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pdm_in = 1'b0;
  logic        sample_en = 1'b0;
  logic [15:0] pcm_out;
  logic        pcm_valid;
  logic        warm;

  int errors = 0;
  int checks = 0;

  // Model state: every accepted sample since reset, plus the output bookkeeping.
  bit          smp[$];
  bit          dly_en[$];
  bit          dly_pdm[$];
  bit          tick_pend;
  int          outs;
  logic [15:0] m_pcm;
  logic        m_valid;
  logic        m_warm;
  int          cyc;
  int          vcyc[$];

  always #5 clk = ~clk;

  pdm_cic_decimator #(.DECIM_LOG2(DL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pdm_in    (pdm_in),
    .sample_en (sample_en),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .warm      (warm)
  );

  function automatic longint c2(longint t);
    return (t < 2) ? 64'sd0 : (t * (t - 1)) / 2;
  endfunction

  // Impulse response of three cascaded length-R boxcars, as seen through the pipelined integrators.
  function automatic longint h(longint t);
    return c2(t) - 3 * c2(t - R) + 3 * c2(t - 2 * R) - c2(t - 3 * R);
  endfunction

  function automatic longint fir(int n);
    longint y = 0;
    int lo = (n - 3 * R + 1 < 1) ? 1 : n - 3 * R + 1;
    for (int j = lo; j <= n; j++) y += longint'(smp[j-1]) * h(longint'(n - j));
    return y;
  endfunction

  task automatic model_reset();
    smp.delete();
    dly_en.delete();
    dly_pdm.delete();
    for (int i = 0; i < LAT; i++) begin
      dly_en.push_back(1'b0);
      dly_pdm.push_back(1'b0);
    end
    tick_pend = 1'b0;
    outs      = 0;
    m_pcm     = 16'h0000;
    m_valid   = 1'b0;
    m_warm    = 1'b0;
    cyc       = 0;
    vcyc.delete();
  endtask

  task automatic model_edge(input bit en, input bit p);
    bit e, x;
    longint y, s;
    dly_en.push_back(en);
    dly_pdm.push_back(p);
    e = dly_en.pop_front();
    x = dly_pdm.pop_front();
    m_valid = 1'b0;
    if (tick_pend) begin
      outs++;
      y = fir(smp.size());
      s = y >> SHIFT;
      m_pcm   = (s > 65535) ? 16'hFFFF : 16'(s);
      m_valid = (outs >= 4);
      m_warm  = (outs >= 3);
      tick_pend = 1'b0;
    end
    if (e) begin
      smp.push_back(x);
      if (smp.size() % R == 0) tick_pend = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit en, input bit p);
    sample_en = en;
    pdm_in    = p;
    @(posedge clk);
    model_edge(en, p);
    cyc++;
    #1;
    chk("pcm_valid", 32'(pcm_valid), 32'(m_valid));
    chk("warm", 32'(warm), 32'(m_warm));
    chk("pcm_out", 32'(pcm_out), 32'(m_pcm));
    if (pcm_valid) vcyc.push_back(cyc);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_pcm"}, 32'(pcm_out), 32'h0);
    chk({tag, "_rst_valid"}, 32'(pcm_valid), 32'h0);
    chk({tag, "_rst_warm"}, 32'(warm), 32'h0);
    model_reset();
    sample_en = 1'b0;
    pdm_in    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_period(input string tag, input int period, input int nexp);
    chk({tag, "_nvalid"}, 32'(vcyc.size()), 32'(nexp));
    for (int i = 1; i < vcyc.size(); i++)
      chk({tag, "_period"}, 32'(vcyc[i] - vcyc[i-1]), 32'(period));
  endtask

  // First-order sigma-delta standing in for the on-chip PDM modulator.
  task automatic loopback(input logic [15:0] val, input int n, inout logic [16:0] acc);
    for (int i = 0; i < n; i++) begin
      acc = {1'b0, acc[15:0]} + {1'b0, val};
      step(1'b1, acc[16]);
    end
  endtask

  initial begin
    logic [16:0] sd_acc;
    int diff;
    model_reset();
    do_reset("init");

    // Random traffic, then an asynchronous reset mid-stream.
    for (int i = 0; i < 40 * R; i++)
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
    #2;
    do_reset("mid");

    // All-ones after reset: first valid on the 4th decimated output, saturated to FFFF.
    for (int i = 0; i < 8 * R + LAT + 2; i++) step(1'b1, 1'b1);
    chk("ones_first_valid", 32'(vcyc.size() > 0 ? vcyc[0] : -1), 32'(4 * R + 1 + LAT));
    chk_period("ones", R, 5);
    chk("ones_value", 32'(pcm_out), 32'hFFFF);

    do_reset("zeros");
    for (int i = 0; i < 6 * R; i++) step(1'b1, 1'b0);
    chk("zeros_value", 32'(pcm_out), 32'h0);
    chk("zeros_warm", 32'(warm), 32'h1);

    do_reset("alt");
    for (int i = 0; i < 6 * R; i++) step(1'b1, bit'(i % 2 == 0));
    chk("alt_value", 32'(pcm_out), 32'h8000);

    // Strobe every 4th cycle: integrators hold in between, period stretches to 4R.
    do_reset("throttle");
    for (int i = 0; i < 32 * R + LAT; i++) step(bit'(i % 4 == 0), 1'b1);
    chk_period("throttle", 4 * R, 5);
    chk("throttle_value", 32'(pcm_out), 32'hFFFF);

    do_reset("loop");
    sd_acc = '0;
    loopback(16'h4000, 8 * R, sd_acc);
    diff = int'(pcm_out) - 32'h4000;
    chk("loop_4000", 32'((diff <= 64) && (diff >= -64)), 32'h1);
    loopback(16'hC000, 8 * R, sd_acc);
    diff = int'(pcm_out) - 32'hC000;
    chk("loop_C000", 32'((diff <= 64) && (diff >= -64)), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
